// File: rtl/aes_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_pkg
// Description : Shared types and GF(2^8) helpers for the iterative AES
//               MixColumns / InvMixColumns datapath.
//               - mix_state_e : controller state encoding (IDLE/BUSY/DONE)
//               - GF_POLY     : low byte of the AES reduction polynomial 0x11B
//               - xtime, gmul2/3/9/11/13/14 : 8-bit in, 8-bit out products
// Revision    : 1.0 - initial release
// ============================================================================
package aes_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mix_state_e;

    localparam logic [7:0] GF_POLY = 8'h1B;

    // Multiply by x modulo x^8+x^4+x^3+x+1; the dropped bit 8 is folded back
    // in through the low byte of the polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // The inverse coefficients all decompose into x, 2x, 4x and 8x terms.
    function automatic logic [7:0] gmul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage : aes_mix_pkg
`default_nettype wire

// File: rtl/mixcol_column.sv
`default_nettype none
// ============================================================================
// Module      : mixcol_column
// Description : Combinational transform of one 32-bit AES state column.
//               Row 0 is the most significant byte.
// Ports       : col_in  [31:0] - input column
//               inv            - 0: MixColumns, 1: InvMixColumns
//               col_out [31:0] - transformed column
// Revision    : 1.0 - initial release
// ============================================================================
module mixcol_column
    import aes_mix_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] f0, f1, f2, f3;
    logic [7:0] i0, i1, i2, i3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Forward circulant {2,3,1,1}
    assign f0 = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
    assign f1 = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
    assign f2 = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
    assign f3 = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);

    // Inverse circulant {14,11,13,9}
    assign i0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign i1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign i2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign i3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

    assign col_out = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule : mixcol_column
`default_nettype wire

// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_iter
// Description : Iterative AES MixColumns / InvMixColumns on a 128-bit state,
//               COLS_PER_CYCLE columns per clock, valid/ready on both sides.
//               Column c of din/dout is bits [127-32c -: 32].
// Parameters  : COLS_PER_CYCLE - 1, 2 or 4 columns per clock
//               OUT_REG        - 1: dedicated output register, 0: dout taken
//                                from the working register
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready, din[127:0], inv   - input side
//               bypass (only with MIXCOL_BYPASS_EN)  - pass din through
//               out_valid/out_ready, dout[127:0]     - output side
// Options     : `define MIXCOL_BYPASS_EN adds the bypass input.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_iter
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit OUT_REG        = 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);

    localparam int         NSTEPS   = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(NSTEPS - 1);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    mix_state_e   state;
    logic [1:0]   cnt;
    logic         mode_inv;
    logic [127:0] work;
    logic [127:0] work_next;
    logic [127:0] work_step;
    logic         accept;
    logic         last_step;
    logic         bypass_en;

    logic [31:0]  lane_in  [COLS_PER_CYCLE];
    logic [31:0]  lane_out [COLS_PER_CYCLE];

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign last_step = (state == BUSY) && (cnt == LAST_CNT);

`ifdef MIXCOL_BYPASS_EN
    logic bypass_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_lat <= 1'b0;
        end else if (accept) begin
            bypass_lat <= bypass;
        end
    end

    assign bypass_en = bypass_lat;
`else
    assign bypass_en = 1'b0;
`endif

    // Column j belongs to step j/C and is handled by lane j%C; the lane
    // inputs are muxed from the working register by the step counter.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            lane_in[k] = 32'h0;
        end
        for (int j = 0; j < 4; j++) begin
            if (cnt == 2'(j / COLS_PER_CYCLE)) begin
                lane_in[j % COLS_PER_CYCLE] = work[127-32*j -: 32];
            end
        end
    end

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
            mixcol_column u_col (
                .col_in  (lane_in[k]),
                .inv     (mode_inv),
                .col_out (lane_out[k])
            );
        end
    endgenerate

    always_comb begin
        work_step = work;
        for (int j = 0; j < 4; j++) begin
            if (cnt == 2'(j / COLS_PER_CYCLE)) begin
                work_step[127-32*j -: 32] = lane_out[j % COLS_PER_CYCLE];
            end
        end
    end

    // Bypassed blocks still walk through every step so timing is unchanged.
    assign work_next = bypass_en ? work : work_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            mode_inv <= 1'b0;
            work     <= 128'h0;
        end else if (accept) begin
            // Covers both IDLE and the DONE hand-off edge.
            state    <= BUSY;
            cnt      <= 2'd0;
            mode_inv <= inv;
            work     <= din;
        end else begin
            case (state)
                BUSY: begin
                    work <= work_next;
                    if (cnt == LAST_CNT) begin
                        cnt   <= 2'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [127:0] dout_q;

            // Loaded on the final step so it becomes valid with out_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= 128'h0;
                end else if (last_step && !accept) begin
                    dout_q <= work_next;
                end
            end

            assign dout = dout_q;
        end else begin : g_out_direct
            assign dout = work;
        end
    endgenerate

endmodule : mix_columns_iter
`default_nettype wire
